// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among four requesters,
// with a lock for unbroken multi-byte messages and a per-byte completion timeout.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  lock,
  output logic [3:0]  ack,
  output logic [3:0]  err,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        tx_en_sig,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_REARB = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic [15:0] r_cnt;
  logic [3:0]  r_ack;
  logic [3:0]  r_err;
  logic        r_busy;
  logic        r_tx_en;
  logic [7:0]  r_tx_data;

  logic [1:0]  w_rr_id;
  logic [1:0]  w_cand;
  logic [1:0]  w_sel_id;
  logic        w_sel_vld;

  // Scan from the farthest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_rr_id = r_ptr;
    w_cand  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) w_rr_id = w_cand;
    end
  end

  always_comb begin
    w_sel_vld = |req;
    w_sel_id  = w_rr_id;
    if ((r_state == S_REARB) && lock[r_grant] && req[r_grant]) w_sel_id = r_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd0;
      r_cnt     <= 16'd0;
      r_ack     <= 4'd0;
      r_err     <= 4'd0;
      r_busy    <= 1'b0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_ack <= 4'd0;
      r_err <= 4'd0;
      case (r_state)
        S_IDLE, S_REARB: begin
          if (w_sel_vld) begin
            r_state   <= S_SEND;
            r_grant   <= w_sel_id;
            r_tx_data <= req_data[{w_sel_id, 3'b000} +: 8];
            r_tx_en   <= 1'b1;
            r_cnt     <= 16'd0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SEND: begin
          r_cnt <= r_cnt + 16'd1;
          // A done arriving on the last allowed cycle still counts as success.
          if (tx_done) begin
            r_state <= S_DONE;
            r_tx_en <= 1'b0;
            r_ack   <= 4'b0001 << r_grant;
          end else if (r_cnt == TIMEOUT - 16'd1) begin
            r_state <= S_DONE;
            r_tx_en <= 1'b0;
            r_err   <= 4'b0001 << r_grant;
          end
        end
        S_DONE: begin
          r_ptr   <= r_grant + 2'd1;
          r_state <= S_REARB;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign grant_id  = r_grant;
  assign busy      = r_busy;
  assign tx_en_sig = r_tx_en;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a message-level round-robin/lock model predicts
// every byte's owner, data and outcome; a monitor checks each ack/err pulse against it.
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         is_err;
    int         run;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx_en_sig;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(16'(TO))) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .lock(lock),
    .ack(ack), .err(err), .grant_id(grant_id), .busy(busy),
    .tx_en_sig(tx_en_sig), .tx_data(tx_data), .tx_done(tx_done)
  );

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  int         lat_q[$];
  int         gorder[$];
  logic [7:0] m_data[4][$];
  bit         m_lk[4][$];
  int         m_lat[4][$];
  int         m_ptr = 0;
  bit         spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: done pulses in the lat-th enabled cycle; lat 0 means never.
  int tx_cnt = 0;
  int tx_lat = 0;
  always @(negedge clk) begin
    tx_done = spurious;
    if (!rst_n || !tx_en_sig) begin
      tx_cnt = 0;
    end else begin
      if (tx_cnt == 0) tx_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      tx_cnt++;
      if (tx_cnt == tx_lat) tx_done = 1'b1;
    end
  end

  // Monitor
  int         run_len = 0;
  int         gap_len = 0;
  bit         gap_busy = 1'b0;
  bit         en_q = 1'b0;
  bit         stable = 1'b1;
  logic [7:0] cap_data = 8'h00;
  logic [1:0] cap_gid = 2'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0; gap_len = 0; gap_busy = 1'b0; en_q = 1'b0;
    end else begin
      if (tx_en_sig) begin
        if (!en_q) begin
          if (gap_busy) check("gap_cycles", 32'(gap_len), 32'd2);
          gap_busy = 1'b0;
          cap_data = tx_data;
          cap_gid  = grant_id;
          gorder.push_back(int'(grant_id));
          run_len  = 0;
          stable   = 1'b1;
        end else if (tx_data !== cap_data || grant_id !== cap_gid) begin
          stable = 1'b0;
        end
        run_len++;
      end else begin
        if (en_q) begin gap_len = 0; gap_busy = 1'b1; end
        gap_len++;
        if (!busy) gap_busy = 1'b0;
      end
      en_q = tx_en_sig;
      if ((ack | err) != 4'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {24'd0, ack, err}, 32'd0);
        end else begin
          exp_t e;
          logic [3:0] lv;
          e  = exp_q.pop_front();
          lv = 4'b0001 << e.id;
          check("resp_ack_err", {24'd0, ack, err}, e.is_err ? {28'd0, lv} : {24'd0, lv, 4'd0});
          check("resp_grant_id", 32'(grant_id), 32'(e.id));
          check("resp_tx_data", 32'(cap_data), 32'(e.data));
          check("resp_en_cycles", 32'(run_len), 32'(e.run));
          check("resp_data_stable", 32'(stable), 32'd1);
          check("resp_en_low", 32'(tx_en_sig), 32'd0);
        end
      end
    end
  end

  task automatic add(input int i, input logic [7:0] d, input bit lk, input int lat);
    m_data[i].push_back(d);
    m_lk[i].push_back(lk);
    m_lat[i].push_back(lat);
  endtask

  // Reference model: whole-message view of who sends which byte, in what order.
  task automatic plan();
    int rem[4];
    int head[4];
    int cur;
    int pick;
    int lat;
    int left;
    exp_t e;
    left = 0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = m_data[i].size(); head[i] = 0; left += rem[i];
    end
    cur = -1;
    while (left > 0) begin
      pick = -1;
      if (cur >= 0 && rem[cur] > 0 && m_lk[cur][head[cur]]) pick = cur;
      else
        for (int k = 0; k < 4; k++)
          if (pick < 0 && rem[(m_ptr + k) % 4] > 0) pick = (m_ptr + k) % 4;
      lat      = m_lat[pick][head[pick]];
      e.id     = pick;
      e.data   = m_data[pick][head[pick]];
      e.is_err = (lat == 0 || lat > TO);
      e.run    = e.is_err ? TO : lat;
      exp_q.push_back(e);
      lat_q.push_back(lat);
      m_ptr = (pick + 1) % 4;
      cur   = pick;
      head[pick]++;
      rem[pick]--;
      left--;
    end
    for (int i = 0; i < 4; i++) m_lat[i].delete();
  endtask

  task automatic agent(input int i);
    int budget;
    while (m_data[i].size() > 0) begin
      req_data[8*i +: 8] = m_data[i][0];
      lock[i] = m_lk[i][0];
      req[i]  = 1'b1;
      budget = 0;
      do begin @(negedge clk); budget++; end while (!(ack[i] | err[i]) && budget < 2000);
      check($sformatf("req%0d_served", i), 32'(ack[i] | err[i]), 32'd1);
      void'(m_data[i].pop_front());
      void'(m_lk[i].pop_front());
    end
    req[i]  = 1'b0;
    lock[i] = 1'b0;
  endtask

  task automatic launch();
    fork
      agent(0); agent(1); agent(2); agent(3);
    join
  endtask

  task automatic drain(input string nm);
    int budget = 0;
    while ((busy || exp_q.size() != 0) && budget < 3000) begin @(negedge clk); budget++; end
    repeat (2) @(negedge clk);
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_scenario(input string nm);
    plan();
    launch();
    drain(nm);
  endtask

  task automatic check_order(input string nm, input int n, input int exp[5]);
    check({nm, "_grants"}, 32'(gorder.size()), 32'(n));
    for (int k = 0; k < n && k < gorder.size(); k++)
      check($sformatf("%s_grant%0d", nm, k), 32'(gorder[k]), 32'(exp[k]));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_tx_en"}, 32'(tx_en_sig), 32'd0);
    check({nm, "_tx_data"}, 32'(tx_data), 32'd0);
    check({nm, "_ack"}, 32'(ack), 32'd0);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_grant_id"}, 32'(grant_id), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'd0; lock = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 4'd0; lock = 4'd0; req_data = 32'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious done while idle
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    spurious = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("spurious_no_resp", {24'd0, ack, err}, 32'd0);
      check("spurious_idle", 32'(busy), 32'd0);
    end

    // Single byte, with req-to-enable latency
    gorder.delete();
    add(2, 8'h55, 1'b0, 12);
    plan();
    fork
      launch();
      begin
        @(negedge clk);
        check("single_en_latency", 32'(tx_en_sig), 32'd1);
        check("single_tx_data", 32'(tx_data), 32'h55);
        check("single_grant_id", 32'(grant_id), 32'd2);
      end
    join
    drain("single");
    check_order("single", 1, '{2, 0, 0, 0, 0});

    // All four contend from reset
    do_reset();
    gorder.delete();
    add(0, 8'h55, 1'b0, $urandom_range(1, TO));
    add(1, 8'hAA, 1'b0, $urandom_range(1, TO));
    add(2, 8'h3B, 1'b0, $urandom_range(1, TO));
    add(3, 8'h7E, 1'b0, $urandom_range(1, TO));
    run_scenario("all4");
    check_order("all4", 4, '{0, 1, 2, 3, 0});

    // Move the pointer to 1, then a locked three-byte message from requester 1
    add(0, 8'h11, 1'b0, 5);
    run_scenario("preload");
    gorder.delete();
    add(1, 8'h01, 1'b0, $urandom_range(1, TO));
    add(1, 8'h02, 1'b1, $urandom_range(1, TO));
    add(1, 8'h03, 1'b1, $urandom_range(1, TO));
    add(0, 8'hA0, 1'b0, $urandom_range(1, TO));
    add(3, 8'hA3, 1'b0, $urandom_range(1, TO));
    run_scenario("locked");
    check_order("locked", 5, '{1, 1, 1, 3, 0});

    // Timeout, done coinciding with the last allowed cycle, and done one cycle too late
    add(0, 8'hC3, 1'b0, 0);
    run_scenario("timeout");
    add(0, 8'h3C, 1'b0, TO);
    run_scenario("tie");
    add(2, 8'h96, 1'b0, TO + 1);
    run_scenario("late_done");

    // Requester 3 appears and withdraws while requester 0 is being served
    gorder.delete();
    add(0, 8'hE7, 1'b0, 12);
    plan();
    fork
      launch();
      begin
        repeat (3) @(negedge clk);
        req_data[31:24] = 8'hF0;
        req[3] = 1'b1;
        repeat (4) @(negedge clk);
        req[3] = 1'b0;
      end
    join
    drain("withdraw");
    check_order("withdraw", 1, '{0, 0, 0, 0, 0});

    // Randomized message mixes
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++)
          add(i, 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 2));
      end
      run_scenario($sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a byte
    req_data[7:0] = 8'h99;
    req[0] = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    req = 4'd0;
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    gorder.delete();
    add(1, 8'h5A, 1'b0, 5);
    add(3, 8'hB4, 1'b0, 7);
    run_scenario("postreset");
    check_order("postreset", 2, '{1, 3, 0, 0, 0});

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter (`tx_module`) between four independent requesters. Each requester presents a byte and a request. The arbiter grants them round-robin, drives the transmitter's level-held enable / done-pulse handshake, and returns a per-requester acknowledge or timeout error. A lock input lets one requester send a multi-byte message without other requesters' bytes being interleaved. The block sits between the application logic and `tx_module`, replacing hand-written step sequencers.

## Interface
- `TIMEOUT`, 16'd2048: cycles allowed in SEND for `tx_done` before the byte is aborted. Legal range 2..65535. The default covers one 10-bit frame at 12 MHz / 115200 (1040 cycles) with margin.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 4: `req[i]` high means requester i has a byte on its data lane. It is held until `ack[i]` or `err[i]`.
- `req_data` in 32: byte for requester i on bits `[8i+7:8i]`. It must be stable while `req[i]` is high.
- `lock` in 4: `lock[i]` high means keep the grant on i after the current byte if `req[i]` is still high.
- `ack` out 4: one-cycle pulse; requester i's byte completed.
- `err` out 4: one-cycle pulse; requester i's byte timed out.
- `grant_id` out 2: index of the current or last granted requester.
- `busy` out 1: high when state is not IDLE.
- `tx_en_sig` out 1: enable to `tx_module`. It is held high until `tx_done`.
- `tx_data` out 8: byte to `tx_module`. It is stable while `tx_en_sig` is high.
- `tx_done` in 1: one-cycle completion pulse from `tx_module`.

## Operation
- State machine has four states: IDLE, SEND, DONE, REARB. All outputs are registered.
- **IDLE:** if any `req` is high, pick the winner round-robin.
  - The search starts at `ptr` and runs `ptr`, `ptr`+1, ... mod 4.
  - Next cycle: state goes to SEND, `grant_id`=g, `tx_data`=`req_data[g]`, `tx_en_sig`=1, timeout counter=0.
- **SEND:** `tx_en_sig` is held at 1 and the counter increments each cycle.
  - If `tx_done`=1: next cycle goes to DONE with `tx_en_sig`=0 and `ack[g]`=1.
  - Else if counter==`TIMEOUT`-1: next cycle goes to DONE with `tx_en_sig`=0 and `err[g]`=1.
  - If `tx_done` and timeout occur in the same cycle, `tx_done` wins and only `ack` fires.
- **DONE:** lasts one cycle. `ack`/`err` are high here only. `ptr` is set to (g+1) mod 4. Next state is REARB.
  - This cycle gives the requester time to register the ack and update `req`/`req_data`/`lock`.
- **REARB:** lasts one cycle and samples `req`, `lock` and `req_data`.
  - If `lock[g]` and `req[g]` are both high: regrant g.
  - Otherwise: run the round-robin search from `ptr`. Because `ptr` is (g+1) mod 4 and the search is mod 4, g is checked last.
  - If a grant is made, next state is SEND, loaded as from IDLE. If no requester is active, next state is IDLE.
- `tx_done` is ignored outside SEND.
- `req` is not tracked while SEND is in progress. Withdrawing `req[i]` before it is granted is legal.
- `lock[i]` on a requester that has no grant has no effect.
- Arithmetic rules:
  - The counter is 16 bits and cannot wrap, because it is cleared on every entry to SEND.
  - `ptr` is 2 bits and wraps naturally from 3 to 0.
- Reset values: `tx_en_sig`=0, `tx_data`=8'h00, `ack`=0, `err`=0, `grant_id`=0, `busy`=0, `ptr`=0, counter=0, state IDLE.
- Reset asserted mid-byte forces these values immediately (asynchronous). `tx_module` shares `rst_n`, so no partial frame resumes.

## Timing
- Latency from `req` to `tx_en_sig`: `req` rises in cycle c (state IDLE), and `tx_en_sig` is high at c+1.
- Latency from `tx_done` to `ack`: `tx_done` in cycle t, `ack` in cycle t+1.
- Back-to-back bytes: `tx_en_sig` is low for exactly two cycles (DONE and REARB), then high again at t+3.
- `tx_en_sig` always drops for at least two cycles between bytes, so `tx_module` re-arms.
- Timeout: `tx_en_sig` is high for exactly `TIMEOUT` cycles, then `err` fires in the next cycle.

## Test plan
- **Single byte:** `req`=4'b0100 with lane 2 = 8'h55, and a `tx_module` model with done after 1040 cycles. Expect `tx_data`=8'h55 one cycle after `req`, `grant_id`=2, `ack`=4'b0100 for exactly one cycle, then IDLE with `busy`=0.
- **All four contend:** `req`=4'b1111 with data 8'h55/8'hAA/8'h3B/8'h7E, starting from reset. Expect grant order 0,1,2,3, one `ack` per requester, and `tx_en_sig` low for exactly two cycles between bytes.
- **Locked message:** requester 1 sends 3 bytes (8'h01, 8'h02, 8'h03) with `lock[1]`=1 until its last byte, while `req[0]` and `req[3]` are high throughout. Expect bytes 01/02/03 to be consecutive, then grant 3 next (ptr=2, so the search finds 3 before 0), then 0.
- **Timeout:** `TIMEOUT`=16, `tx_done` never asserted, `req`=4'b0001. Expect `tx_en_sig` high for 16 cycles, `err`=4'b0001 for one cycle, no `ack`. Also drive `tx_done` in the same cycle as the timeout: expect only `ack`.
- **Reset mid-byte:** assert `rst_n`=0 asynchronously during SEND. Expect all outputs zero immediately. After release with `req`=4'b0010, expect the grant to go to 1 (ptr reset to 0).
- **Spurious done and withdraw:**
  - Pulse `tx_done` in IDLE: no `ack`.
  - Raise then drop `req[3]` while requester 0 is being served: requester 3 is never granted.
